// File: rtl/core_jmp_mlane.sv
// Multi-lane branch resolution: picks the oldest mispredict, issues a registered
// redirect, squashes the following cycle and queues BPU training records.
package core_jmp_mlane_pkg;
  typedef struct packed {
    logic        taken;
    logic [31:0] predict_pc;
    logic        dir_type;
    logic [1:0]  target_type;
    logic [7:0]  lphr;
    logic [7:0]  history;
    logic [3:0]  ras_ptr;
  } bpu_predict_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] true_target;
    logic        true_taken;
    logic        miss;
    logic        true_dir_type;
    logic        miss_dir_type;
    logic [1:0]  true_target_type;
    logic        miss_target_type;
    logic [7:0]  lphr;
    logic [7:0]  history;
    logic [3:0]  ras_ptr;
  } bpu_correct_t;
endpackage

module core_jmp_mlane
  import core_jmp_mlane_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned UPD_DEPTH = 8,
  parameter int unsigned DROP_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES-1:0]      valid_i,
  input  logic [LANES*2-1:0]    target_type_i,
  input  logic [LANES*4-1:0]    cmp_type_i,
  input  bpu_predict_t [LANES-1:0] bpu_predict_i,
  input  logic [LANES*32-1:0]   pc_i,
  input  logic [LANES*32-1:0]   target_i,
  input  logic [LANES*32-1:0]   r0_i,
  input  logic [LANES*32-1:0]   r1_i,
  output logic                  jmp_o,
  output logic [31:0]           redirect_pc_o,
  output logic                  upd_valid_o,
  output bpu_correct_t          upd_o,
  input  logic                  upd_ready_i,
  output logic [DROP_W-1:0]     drop_cnt_o
);

  localparam int unsigned AW = $clog2(UPD_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [LANES-1:0] true_taken, lane_act, lane_miss, surv, wr_en;
  logic [AW-1:0]    wr_off [LANES];
  bpu_correct_t     rec    [LANES];
  bpu_correct_t     mem    [UPD_DEPTH];
  logic [CW-1:0]    count, free, n_acc, n_drop;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             any_miss, pop;
  logic [31:0]      redirect_nxt;
  logic [DROP_W:0]  drop_sum;

  always_comb begin
    logic [32:0]  a0, a1;
    logic [3:0]   c;
    logic [31:0]  pcv, tgt;
    bpu_predict_t p;
    logic         alive;
    true_taken   = '0;
    lane_act     = '0;
    lane_miss    = '0;
    surv         = '0;
    wr_en        = '0;
    any_miss     = 1'b0;
    redirect_nxt = redirect_pc_o;
    n_acc        = '0;
    n_drop       = '0;
    alive        = 1'b1;
    free         = CW'(UPD_DEPTH) - count;
    for (int unsigned i = 0; i < LANES; i++) begin
      c   = cmp_type_i[i*4 +: 4];
      pcv = pc_i[i*32 +: 32];
      tgt = target_i[i*32 +: 32];
      p   = bpu_predict_i[i];
      // Bit 32 flips the sign ordering so one unsigned compare covers both modes.
      a0  = {~r0_i[i*32+31] & c[0], r0_i[i*32 +: 32]};
      a1  = {~r1_i[i*32+31] & c[0], r1_i[i*32 +: 32]};
      true_taken[i] = |({a1 < a0, a1 == a0, a1 > a0} & c[3:1]);
      lane_act[i]   = valid_i[i] & ~jmp_o;
      lane_miss[i]  = lane_act[i] & (true_taken[i] | p.taken) &
                      ((p.taken != true_taken[i]) | (p.predict_pc != tgt));

      rec[i].pc               = pcv;
      rec[i].true_target      = tgt;
      rec[i].true_taken       = true_taken[i];
      rec[i].miss             = lane_miss[i];
      rec[i].true_dir_type    = (|c[3:1]) & (c[3:1] != 3'b111);
      rec[i].miss_dir_type    = rec[i].true_dir_type != p.dir_type;
      rec[i].true_target_type = target_type_i[i*2 +: 2];
      rec[i].miss_target_type = target_type_i[i*2 +: 2] != p.target_type;
      rec[i].lphr             = p.lphr;
      rec[i].history          = p.history;
      rec[i].ras_ptr          = p.ras_ptr;

      // Accepted lanes are contiguous from the oldest, so overflow drops the youngest.
      surv[i]   = lane_act[i] & alive;
      wr_off[i] = n_acc[AW-1:0];
      if (surv[i]) begin
        if (n_acc < free) begin
          wr_en[i] = 1'b1;
          n_acc    = n_acc + CW'(1);
        end else begin
          n_drop   = n_drop + CW'(1);
        end
      end
      if (lane_miss[i] && alive) begin
        any_miss     = 1'b1;
        redirect_nxt = true_taken[i] ? tgt : pcv + 32'd4;
        alive        = 1'b0;
      end
    end
  end

  assign upd_valid_o = (count != '0);
  assign upd_o       = upd_valid_o ? mem[rd_ptr] : '0;
  assign pop         = upd_valid_o & upd_ready_i;
  assign drop_sum    = {1'b0, drop_cnt_o} + (DROP_W+1)'(n_drop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jmp_o         <= 1'b0;
      redirect_pc_o <= '0;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      drop_cnt_o    <= '0;
    end else begin
      jmp_o <= any_miss;
      if (any_miss) redirect_pc_o <= redirect_nxt;
      count  <= count + n_acc - CW'(pop);
      wr_ptr <= wr_ptr + n_acc[AW-1:0];
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      drop_cnt_o <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wr_en[i]) mem[wr_ptr + wr_off[i]] <= rec[i];
    end
  end

endmodule
